// File: rtl/aes_pkg.sv
// Shared AES types, block size and the ShiftRows byte-index mapping.
// Inverse mapping is only exercised when SHIFT_ROWS_INV_MODE_EN is defined.
`default_nettype none

package aes_pkg;

   localparam int AES_BLK_BYTES = 16;

   typedef logic [7:0] aes_byte_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      FULL  = 2'd2
   } bank_state_e;

   // Output byte 4c+r is sourced from column (c+r)%4 (forward) or (c-r)%4 (inverse), same row.
   function automatic logic [3:0] sr_map(input logic [3:0] idx, input logic inv);
      logic [1:0] col;
      logic [1:0] row;
      logic [1:0] src;
      col = idx[3:2];
      row = idx[1:0];
      src = inv ? (col - row) : (col + row);
      return {src, row};
   endfunction

endpackage

`default_nettype wire

// File: rtl/shift_rows_bank.sv
// ============================================================================
//  shift_rows_bank : 16-byte state buffer, one write port, ShiftRows-mapped read
//  Revision 1.0
// ============================================================================
`default_nettype none

module shift_rows_bank
   import aes_pkg::*;
#(
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [3:0]        waddr_i,
   input  logic [BYTE_W-1:0] wdata_i,
   input  logic [3:0]        raddr_i,
   input  logic              inv_i,
   output logic [BYTE_W-1:0] rdata_o
);

   logic [BYTE_W-1:0] mem_q [AES_BLK_BYTES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < AES_BLK_BYTES; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[sr_map(raddr_i, inv_i)];

endmodule

`default_nettype wire

// File: rtl/shift_rows_stream.sv
// ============================================================================
//  shift_rows_stream : byte-serial AES ShiftRows stage with BANKS state buffers
//  Optional macro SHIFT_ROWS_INV_MODE_EN adds the inv port (inverse ShiftRows).
//  Revision 1.0
// ============================================================================
`default_nettype none

module shift_rows_stream
   import aes_pkg::*;
#(
   parameter int BANKS  = 2,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [BYTE_W-1:0] s_data,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [BYTE_W-1:0] m_data,
   output logic              m_last,
   output logic              err
`ifdef SHIFT_ROWS_INV_MODE_EN
   ,
   input  logic              inv
`endif
);

   localparam int            BW        = (BANKS > 1) ? $clog2(BANKS) : 1;
   localparam logic [BW-1:0] LAST_BANK = BW'(BANKS - 1);

   if (BYTE_W != 8) begin : g_bad_byte_w
      $error("shift_rows_stream: BYTE_W must be 8");
   end
   if (BANKS < 1) begin : g_bad_banks
      $error("shift_rows_stream: BANKS must be at least 1");
   end

   bank_state_e       bank_st_q [BANKS];
   bank_state_e       bank_st_d [BANKS];
   logic              inv_q     [BANKS];
   logic              inv_d     [BANKS];
   logic [BW-1:0]     wr_bank_q, wr_bank_d;
   logic [BW-1:0]     rd_bank_q, rd_bank_d;
   logic [3:0]        wr_idx_q,  wr_idx_d;
   logic [3:0]        rd_idx_q,  rd_idx_d;
   logic              err_q,     err_d;

   logic              w_s_fire;
   logic              w_m_fire;
   logic              w_wr_done;
   logic              w_rd_done;
   logic              w_inv_in;
   logic              w_bank_we [BANKS];
   logic [BYTE_W-1:0] w_rdata   [BANKS];

`ifdef SHIFT_ROWS_INV_MODE_EN
   assign w_inv_in = inv;
`else
   assign w_inv_in = 1'b0;
`endif

   assign s_ready   = (bank_st_q[wr_bank_q] != FULL);
   assign m_valid   = (bank_st_q[rd_bank_q] == FULL);
   assign w_s_fire  = s_valid && s_ready;
   assign w_m_fire  = m_valid && m_ready;
   assign w_wr_done = (wr_idx_q == 4'd15);
   assign w_rd_done = (rd_idx_q == 4'd15);
   assign m_last    = w_rd_done;
   assign m_data    = m_valid ? w_rdata[rd_bank_q] : '0;
   assign err       = err_q;

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      assign w_bank_we[b] = w_s_fire && (wr_bank_q == BW'(b));

      shift_rows_bank #(
         .BYTE_W (BYTE_W)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .we_i    (w_bank_we[b]),
         .waddr_i (wr_idx_q),
         .wdata_i (s_data),
         .raddr_i (rd_idx_q),
         .inv_i   (inv_q[b]),
         .rdata_o (w_rdata[b])
      );
   end

   // Fill and drain completions touch different banks, so both updates can apply in one cycle.
   always_comb begin
      bank_st_d = bank_st_q;
      inv_d     = inv_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      wr_idx_d  = wr_idx_q;
      rd_idx_d  = rd_idx_q;
      err_d     = err_q;

      if (w_s_fire) begin
         wr_idx_d             = wr_idx_q + 4'd1;
         bank_st_d[wr_bank_q] = w_wr_done ? FULL : FILL;
         if (wr_idx_q == 4'd0) begin
            inv_d[wr_bank_q] = w_inv_in;
         end
         if (s_last != w_wr_done) begin
            err_d = 1'b1;
         end
         if (w_wr_done) begin
            wr_bank_d = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + 1'b1;
         end
      end

      if (w_m_fire) begin
         rd_idx_d = rd_idx_q + 4'd1;
         if (w_rd_done) begin
            bank_st_d[rd_bank_q] = EMPTY;
            rd_bank_d            = (rd_bank_q == LAST_BANK) ? '0 : rd_bank_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < BANKS; b++) begin
            bank_st_q[b] <= EMPTY;
            inv_q[b]     <= 1'b0;
         end
         wr_bank_q <= '0;
         rd_bank_q <= '0;
         wr_idx_q  <= '0;
         rd_idx_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         for (int b = 0; b < BANKS; b++) begin
            bank_st_q[b] <= bank_st_d[b];
            inv_q[b]     <= inv_d[b];
         end
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         wr_idx_q  <= wr_idx_d;
         rd_idx_q  <= rd_idx_d;
         err_q     <= err_d;
      end
   end

endmodule

`default_nettype wire
